// File: rtl/alu_seq_arbiter.sv
// rtl/alu_seq_arbiter.sv - round-robin arbiter and sequencer sharing one registered ALU between two requesters
//
// Purpose: grants one of two requesters, issues its op to the ALU, waits out
// the ALU result (1 cycle) and zero-flag (2 cycle) latencies, and returns the
// result and zero flag to the requester that issued the op.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   reqX_valid/op/a/b/ready    request channel of requester X (X = 0, 1)
//   rspX_valid/data/zero       one-cycle response pulse to requester X
//   rspX_err                   op-7 error flag (only with ALU_SEQ_OPCHECK_EN)
//   alu_in1/alu_in2/alu_op     registered operand/opcode drive to the ALU
//   alu_res, alu_z             ALU result and zero flag (bit 0 used)
//   busy                       high whenever the sequencer is not idle
//
// Optional feature: define ALU_SEQ_OPCHECK_EN to short-circuit op 3'd7
// requests with an error response instead of issuing them.

module alu_seq_arbiter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [2:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    output logic         rsp0_valid,
    output logic [N-1:0] rsp0_data,
    output logic         rsp0_zero,
    input  logic         req1_valid,
    input  logic [2:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp1_data,
    output logic         rsp1_zero,
    output logic [N-1:0] alu_in1,
    output logic [N-1:0] alu_in2,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_res,
    input  logic [15:0]  alu_z,
`ifdef ALU_SEQ_OPCHECK_EN
    output logic         rsp0_err,
    output logic         rsp1_err,
`endif
    output logic         busy
);

    localparam logic [2:0] OP_HOLD = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WAIT1 = 2'd2,
        WAIT2 = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;       // last grantee; 1 after reset so requester 0 wins first
    logic           owner_q, owner_d;
    logic [N-1:0]   alu_in1_q, alu_in1_d;
    logic [N-1:0]   alu_in2_q, alu_in2_d;
    logic [2:0]     alu_op_q, alu_op_d;
    logic           rsp0_valid_q, rsp0_valid_d;
    logic [N-1:0]   rsp0_data_q, rsp0_data_d;
    logic           rsp0_zero_q, rsp0_zero_d;
    logic           rsp1_valid_q, rsp1_valid_d;
    logic [N-1:0]   rsp1_data_q, rsp1_data_d;
    logic           rsp1_zero_q, rsp1_zero_d;
    logic           grant0, grant1;
    logic [N-1:0]   rsp_data;
    logic           rsp_zero;
    logic           unused_alu_z;

`ifdef ALU_SEQ_OPCHECK_EN
    logic           op_err_q, op_err_d;
    logic           rsp0_err_q, rsp0_err_d;
    logic           rsp1_err_q, rsp1_err_d;
`endif

    assign unused_alu_z = ^alu_z[15:1];

    // With both valid, the requester opposite the last grantee wins.
    assign grant0 = req0_valid & (~req1_valid | ptr_q);
    assign grant1 = req1_valid & (~req0_valid | ~ptr_q);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_op_d     = alu_op_q;
        rsp0_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp0_zero_d  = rsp0_zero_q;
        rsp1_valid_d = 1'b0;
        rsp1_data_d  = rsp1_data_q;
        rsp1_zero_d  = rsp1_zero_q;
        rsp_data     = alu_res;
        rsp_zero     = alu_z[0];
`ifdef ALU_SEQ_OPCHECK_EN
        op_err_d     = op_err_q;
        rsp0_err_d   = 1'b0;
        rsp1_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    alu_in1_d = grant1 ? req1_a  : req0_a;
                    alu_in2_d = grant1 ? req1_b  : req0_b;
                    alu_op_d  = grant1 ? req1_op : req0_op;
                    ptr_d     = grant1;
                    owner_d   = grant1;
                    state_d   = EXEC;
`ifdef ALU_SEQ_OPCHECK_EN
                    // An op-7 request never reaches the ALU: alu_op is loaded
                    // with the hold code itself and the response is immediate.
                    op_err_d = (alu_op_d == OP_HOLD);
                    if (op_err_d) begin
                        state_d = WAIT2;
                    end
`endif
                end
            end
            EXEC: begin
                // The ALU samples the op on this edge; hold afterwards so
                // alu_res stays put while the zero flag catches up.
                alu_op_d = OP_HOLD;
                state_d  = WAIT1;
            end
            WAIT1: begin
                state_d = WAIT2;
            end
            WAIT2: begin
                state_d = IDLE;
`ifdef ALU_SEQ_OPCHECK_EN
                if (op_err_q) begin
                    rsp_data = '0;
                    rsp_zero = 1'b0;
                end
                rsp0_err_d = op_err_q & ~owner_q;
                rsp1_err_d = op_err_q & owner_q;
`endif
                if (owner_q) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_data_d  = rsp_data;
                    rsp1_zero_d  = rsp_zero;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_data_d  = rsp_data;
                    rsp0_zero_d  = rsp_zero;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b1;
            owner_q      <= 1'b0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_op_q     <= OP_HOLD;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_zero_q  <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_op_q     <= alu_op_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_zero_q  <= rsp0_zero_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_zero_q  <= rsp1_zero_d;
        end
    end

`ifdef ALU_SEQ_OPCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_err_q   <= 1'b0;
            rsp0_err_q <= 1'b0;
            rsp1_err_q <= 1'b0;
        end else begin
            op_err_q   <= op_err_d;
            rsp0_err_q <= rsp0_err_d;
            rsp1_err_q <= rsp1_err_d;
        end
    end

    assign rsp0_err = rsp0_err_q;
    assign rsp1_err = rsp1_err_q;
`endif

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_zero  = rsp0_zero_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_zero  = rsp1_zero_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_op     = alu_op_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// tb/tb_alu_seq_arbiter.sv - self-checking bench for alu_seq_arbiter with a registered ALU model
module tb_alu_seq_arbiter;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [2:0]   req0_op, req1_op;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic [N-1:0] rsp0_data, rsp1_data;
    logic         rsp0_zero, rsp1_zero;
    logic [N-1:0] alu_in1, alu_in2;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_res = '0;
    logic [15:0]  alu_z = 16'hFFFE;
    logic         busy;
`ifdef ALU_SEQ_OPCHECK_EN
    logic         rsp0_err, rsp1_err;
`endif

    int checks = 0;
    int failures = 0;
    logic [N-1:0] last_data [2];
    logic         last_zero [2];

    always #5 clk = ~clk;

    alu_seq_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_res(alu_res), .alu_z(alu_z),
`ifdef ALU_SEQ_OPCHECK_EN
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
        .busy(busy)
    );

    // Registered ALU: result one edge after the op, zero flag one edge later.
    // Upper z bits are deliberately nonzero; only bit 0 is meaningful.
    function automatic logic [N-1:0] alu_f(input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
        case (op)
            3'd0:    alu_f = x;
            3'd1:    alu_f = x + y;
            3'd2:    alu_f = x - y;
            3'd3:    alu_f = x * y;
            3'd4:    alu_f = x << 4;
            3'd5:    alu_f = x << 1;
            3'd6:    alu_f = x >> 1;
            default: alu_f = x;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_op != 3'd7) alu_res <= alu_f(alu_op, alu_in1, alu_in2);
        alu_z <= {15'h7FFF, alu_res == '0};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input bit id);
        return id ? req1_ready : req0_ready;
    endfunction
    function automatic logic rv(input bit id);
        return id ? rsp1_valid : rsp0_valid;
    endfunction
    function automatic logic [N-1:0] rd(input bit id);
        return id ? rsp1_data : rsp0_data;
    endfunction
    function automatic logic rz(input bit id);
        return id ? rsp1_zero : rsp0_zero;
    endfunction

    task automatic drive(input bit id, input logic v, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Called at a negedge with the DUT idle; issues one op and follows it
    // through EXEC, WAIT1, WAIT2 and the response cycle.
    task automatic run_op(input bit id, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_d, input logic exp_z);
        drive(id, 1'b1, op, a, b);
        #1 chk("ready_at_e0", rdy(id), 1'b1);
        @(negedge clk);
        drive(id, 1'b0, op, a, b);
        #1;
        chk("exec_busy", busy, 1'b1);
        chk("exec_alu_op", alu_op, op);
        chk("exec_alu_in1", alu_in1, a);
        chk("exec_alu_in2", alu_in2, b);
        chk("exec_ready", {req0_ready, req1_ready}, 2'b00);
        chk("exec_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        @(negedge clk);
        chk("wait1_alu_op_hold", alu_op, 3'd7);
        chk("wait1_busy", busy, 1'b1);
        chk("wait1_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        @(negedge clk);
        chk("wait2_busy", busy, 1'b1);
        chk("wait2_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        @(negedge clk);
        chk("rsp_valid_owner", rv(id), 1'b1);
        chk("rsp_valid_other", rv(!id), 1'b0);
        chk("rsp_data", rd(id), exp_d);
        chk("rsp_zero", rz(id), exp_z);
        chk("other_data_held", rd(!id), last_data[!id]);
        chk("other_zero_held", rz(!id), last_zero[!id]);
        chk("idle_after_rsp", busy, 1'b0);
`ifdef ALU_SEQ_OPCHECK_EN
        chk("rsp_err_clear", {rsp0_err, rsp1_err}, 2'b00);
`endif
        last_data[id] = exp_d;
        last_zero[id] = exp_z;
        @(negedge clk);
        chk("rsp_pulse_one_cycle", {rsp0_valid, rsp1_valid}, 2'b00);
    endtask

    typedef struct {
        bit           id;
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_d;
        logic         exp_z;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b0, 3'd1, 16'd5,    16'd7,    16'd12,   1'b0}; // add
        vecs[1] = '{1'b1, 3'd2, 16'd9,    16'd9,    16'd0,    1'b1}; // sub to zero
        vecs[2] = '{1'b0, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1}; // add wrap
        vecs[3] = '{1'b1, 3'd4, 16'h0001, 16'h0000, 16'h0010, 1'b0}; // shl by i=4
        vecs[4] = '{1'b0, 3'd3, 16'h0100, 16'h0101, 16'h0100, 1'b0}; // mul low bits
        vecs[5] = '{1'b1, 3'd5, 16'h8001, 16'h0000, 16'h0002, 1'b0}; // shl1 drops msb
        vecs[6] = '{1'b1, 3'd6, 16'h0011, 16'h0000, 16'h0008, 1'b0}; // shr1
        vecs[7] = '{1'b0, 3'd0, 16'h0042, 16'h1234, 16'h0042, 1'b0}; // pass
        last_data[0] = '0; last_data[1] = '0;
        last_zero[0] = 1'b0; last_zero[1] = 1'b0;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, '0, '0);
        drive(1'b1, 1'b0, 3'd0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_alu_op", alu_op, 3'd7);
        chk("reset_alu_in", {alu_in1, alu_in2}, 32'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rsp", {rsp0_valid, rsp0_zero, rsp1_valid, rsp1_zero}, 4'b0);
        chk("reset_rsp_data", {rsp0_data, rsp1_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_z);

        // Op 7 after a result of 0x0042.
`ifdef ALU_SEQ_OPCHECK_EN
        drive(1'b0, 1'b1, 3'd7, 16'h0055, 16'h0001);
        #1 chk("op7_ready", req0_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd7, 16'h0055, 16'h0001);
        chk("op7_busy", busy, 1'b1);
        chk("op7_alu_op", alu_op, 3'd7);
        chk("op7_no_rsp_yet", rsp0_valid, 1'b0);
        @(negedge clk);
        chk("op7_rsp_valid", rsp0_valid, 1'b1);
        chk("op7_rsp_err", rsp0_err, 1'b1);
        chk("op7_rsp_data", rsp0_data, 16'h0000);
        chk("op7_rsp_zero", rsp0_zero, 1'b0);
        chk("op7_idle", busy, 1'b0);
        @(negedge clk);
        chk("op7_err_pulse", {rsp0_valid, rsp0_err}, 2'b00);
        last_data[0] = 16'h0000;
`else
        run_op(1'b0, 3'd7, 16'h0055, 16'h0001, 16'h0042, 1'b0);
`endif

        // Reset while req0's op sits in WAIT1; pointer now favours requester 1.
        drive(1'b0, 1'b1, 3'd1, 16'h0010, 16'h0020);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd1, 16'h0010, 16'h0020);
        @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_alu_op", alu_op, 3'd7);
        chk("async_reset_alu_in1", alu_in1, 16'h0);
        chk("async_reset_rsp0_data", rsp0_data, 16'h0);
        chk("async_reset_rsp1_data", rsp1_data, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", {rsp0_valid, rsp1_valid, busy}, 3'b000);
        end

        // Both valid continuously: grants alternate 0,1,0,1 every 4 cycles.
        drive(1'b0, 1'b1, 3'd3, 16'd3, 16'd4);
        drive(1'b1, 1'b1, 3'd6, 16'd16, 16'd0);
        for (int c = 0; c <= 16; c++) begin
            #1;
            chk("rr_ready0", req0_ready, (c % 8) == 0);
            chk("rr_ready1", req1_ready, (c % 8) == 4);
            chk("rr_rsp0_valid", rsp0_valid, (c % 8) == 4);
            chk("rr_rsp1_valid", rsp1_valid, (c > 0) && ((c % 8) == 0));
            if (rsp0_valid) chk("rr_rsp0_data", {rsp0_zero, rsp0_data}, {1'b0, 16'd12});
            if (rsp1_valid) chk("rr_rsp1_data", {rsp1_zero, rsp1_data}, {1'b0, 16'd8});
            if (c == 16) begin
                drive(1'b0, 1'b0, 3'd0, '0, '0);
                drive(1'b1, 1'b0, 3'd0, '0, '0);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        chk("rr_stop_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
